// File: rtl/multicast_enqueueing_unit_pkg.sv
// Shared constants and helpers for the multicast enqueue controller.
// Default widths mirror the PE datapath configuration.
package multicast_enqueueing_unit_pkg;

  localparam int TIA_NUM_OUTPUT_CHANNELS = 4;
  localparam int TIA_OCT_WIDTH = 3;
  localparam int TIA_WORD_WIDTH = 32;
  localparam int DEFAULT_CREDIT_DEPTH = 4;

  localparam int MULTICAST_ATOMIC = 0;
  localparam int MULTICAST_PARTIAL = 1;

  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/multicast_enqueueing_unit_channel_credit_counter.sv
// Per-channel downstream credit counter.
// Saturates at full depth and latches an overflow flag.
module channel_credit_counter
  import multicast_enqueueing_unit_pkg::*;
#(
  parameter int CREDIT_DEPTH = DEFAULT_CREDIT_DEPTH
) (
  input  logic clock,
  input  logic reset,
  input  logic decrement,
  input  logic increment,
  output logic has_credit,
  output logic overflow
);

  localparam int CW = credit_width(CREDIT_DEPTH);
  localparam logic [CW-1:0] FULL = CW'(CREDIT_DEPTH);

  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count    <= FULL;
      overflow <= 1'b0;
    end else begin
      unique case ({decrement, increment})
        2'b10: count <= count - CW'(1);
        2'b01: begin
          if (count == FULL) overflow <= 1'b1;
          else count <= count + CW'(1);
        end
        default: count <= count;
      endcase
    end
  end

  assign has_credit = (count != '0);

endmodule

// File: rtl/multicast_enqueueing_unit.sv
// Output enqueue controller: holds one multicast request and fires
// per-channel strobes as downstream credit allows.
module multicast_enqueueing_unit
  import multicast_enqueueing_unit_pkg::*;
#(
  parameter int NUM_OUTPUT_CHANNELS = TIA_NUM_OUTPUT_CHANNELS,
  parameter int TAG_WIDTH = TIA_OCT_WIDTH,
  parameter int DATA_WIDTH = TIA_WORD_WIDTH,
  parameter int CREDIT_DEPTH = DEFAULT_CREDIT_DEPTH,
  parameter int PARTIAL_MULTICAST = MULTICAST_PARTIAL
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic [NUM_OUTPUT_CHANNELS-1:0] oci,
  input  logic [TAG_WIDTH-1:0] oct,
  input  logic [DATA_WIDTH-1:0] data,
  output logic ready,
  input  logic [NUM_OUTPUT_CHANNELS-1:0] credit_returns,
  output logic [NUM_OUTPUT_CHANNELS-1:0] enqueue_signals,
  output logic [NUM_OUTPUT_CHANNELS-1:0][TAG_WIDTH-1:0] output_channel_tags,
  output logic [NUM_OUTPUT_CHANNELS-1:0][DATA_WIDTH-1:0] output_channel_data,
  output logic [NUM_OUTPUT_CHANNELS-1:0] pending_mask,
  output logic credit_error
);

  localparam int N = NUM_OUTPUT_CHANNELS;

  logic pending_valid;
  logic [N-1:0] held_mask;
  logic [TAG_WIDTH-1:0] held_tag;
  logic [DATA_WIDTH-1:0] held_data;
  logic [N-1:0] has_credit;
  logic [N-1:0] overflow;
  logic [N-1:0] fire;
  logic [N-1:0] remain;
  logic accept;

  always_comb begin
    fire = '0;
    if (pending_valid) begin
      if (PARTIAL_MULTICAST == MULTICAST_PARTIAL)
        fire = held_mask & has_credit;
      else if ((held_mask & ~has_credit) == '0)
        fire = held_mask;
    end
  end

  assign remain = held_mask & ~fire;
  assign ready  = !pending_valid || (remain == '0);
  assign accept = enable && ready && (oci != '0);

  // A request accepted as the previous one drains overwrites it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_valid <= 1'b0;
      held_mask     <= '0;
      held_tag      <= '0;
      held_data     <= '0;
    end else if (accept) begin
      pending_valid <= 1'b1;
      held_mask     <= oci;
      held_tag      <= oct;
      held_data     <= data;
    end else begin
      held_mask <= remain;
      if (remain == '0) pending_valid <= 1'b0;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    channel_credit_counter #(
      .CREDIT_DEPTH(CREDIT_DEPTH)
    ) u_cnt (
      .clock     (clock),
      .reset     (reset),
      .decrement (fire[i]),
      .increment (credit_returns[i]),
      .has_credit(has_credit[i]),
      .overflow  (overflow[i])
    );
  end

  always_comb begin
    output_channel_tags = '0;
    output_channel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (fire[i]) begin
        output_channel_tags[i] = held_tag;
        output_channel_data[i] = held_data;
      end
    end
  end

  assign enqueue_signals = fire;
  assign pending_mask    = pending_valid ? held_mask : '0;
  assign credit_error    = |overflow;

endmodule

// File: tb/tb_multicast_enqueueing_unit.sv
// Scoreboard bench: three instances (partial/depth2, atomic/depth2,
// partial/depth4) driven with directed vectors.
module tb_multicast_enqueueing_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       en_i  [3];
  logic [3:0] oci_i [3];
  logic [2:0] oct_i [3];
  logic [7:0] dat_i [3];
  logic [3:0] cret_i[3];

  logic             rdy_o [3];
  logic [3:0]       enq_o [3];
  logic [3:0][2:0]  tag_o [3];
  logic [3:0][7:0]  dat_o [3];
  logic [3:0]       pm_o  [3];
  logic             cerr_o[3];

  int depth[3] = '{2, 2, 4};

  multicast_enqueueing_unit #(
    .NUM_OUTPUT_CHANNELS(4), .TAG_WIDTH(3), .DATA_WIDTH(8),
    .CREDIT_DEPTH(2), .PARTIAL_MULTICAST(1)
  ) u_p2 (
    .clock(clk), .reset(rst_n), .enable(en_i[0]), .oci(oci_i[0]),
    .oct(oct_i[0]), .data(dat_i[0]), .ready(rdy_o[0]),
    .credit_returns(cret_i[0]), .enqueue_signals(enq_o[0]),
    .output_channel_tags(tag_o[0]), .output_channel_data(dat_o[0]),
    .pending_mask(pm_o[0]), .credit_error(cerr_o[0])
  );

  multicast_enqueueing_unit #(
    .NUM_OUTPUT_CHANNELS(4), .TAG_WIDTH(3), .DATA_WIDTH(8),
    .CREDIT_DEPTH(2), .PARTIAL_MULTICAST(0)
  ) u_a2 (
    .clock(clk), .reset(rst_n), .enable(en_i[1]), .oci(oci_i[1]),
    .oct(oct_i[1]), .data(dat_i[1]), .ready(rdy_o[1]),
    .credit_returns(cret_i[1]), .enqueue_signals(enq_o[1]),
    .output_channel_tags(tag_o[1]), .output_channel_data(dat_o[1]),
    .pending_mask(pm_o[1]), .credit_error(cerr_o[1])
  );

  multicast_enqueueing_unit #(
    .NUM_OUTPUT_CHANNELS(4), .TAG_WIDTH(3), .DATA_WIDTH(8),
    .CREDIT_DEPTH(4), .PARTIAL_MULTICAST(1)
  ) u_p4 (
    .clock(clk), .reset(rst_n), .enable(en_i[2]), .oci(oci_i[2]),
    .oct(oct_i[2]), .data(dat_i[2]), .ready(rdy_o[2]),
    .credit_returns(cret_i[2]), .enqueue_signals(enq_o[2]),
    .output_channel_tags(tag_o[2]), .output_channel_data(dat_o[2]),
    .pending_mask(pm_o[2]), .credit_error(cerr_o[2])
  );

  typedef struct {
    int         dut;
    int         cyc;
    logic [3:0] enq;
    logic [3:0] pm;
    logic       rdy;
    logic       cerr;
    logic [2:0] tag;
    logic [7:0] dat;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int outst[3][4];

  always @(posedge clk) cyc++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic e, input logic [3:0] m,
                       input logic [2:0] t, input logic [7:0] v);
    en_i[d]  = e;
    oci_i[d] = m;
    oct_i[d] = t;
    dat_i[d] = v;
  endtask

  task automatic push_exp(input int d, input logic [3:0] enq,
                          input logic [3:0] pm, input logic rdy,
                          input logic cerr, input logic [2:0] tag,
                          input logic [7:0] dat);
    exp_t e;
    e.dut = d; e.cyc = cyc; e.enq = enq; e.pm = pm;
    e.rdy = rdy; e.cerr = cerr; e.tag = tag; e.dat = dat;
    sb.push_back(e);
  endtask

  task automatic check(input exp_t e);
    logic [3:0][2:0] et;
    logic [3:0][7:0] ed;
    int d;
    d = e.dut;
    for (int c = 0; c < 4; c++) begin
      et[c] = e.enq[c] ? e.tag : 3'd0;
      ed[c] = e.enq[c] ? e.dat : 8'd0;
    end
    vectors++;
    if (enq_o[d] !== e.enq || pm_o[d] !== e.pm || rdy_o[d] !== e.rdy ||
        cerr_o[d] !== e.cerr || tag_o[d] !== et || dat_o[d] !== ed) begin
      miscompares++;
      $display("FAIL dut%0d cyc%0d got/want enq=%b/%b pm=%b/%b rdy=%b/%b cerr=%b/%b tags=%h/%h data=%h/%h",
               d, e.cyc, enq_o[d], e.enq, pm_o[d], e.pm, rdy_o[d], e.rdy,
               cerr_o[d], e.cerr, tag_o[d], et, dat_o[d], ed);
    end
  endtask

  // Monitor: compare due entries and guard against credit underflow.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) check(sb.pop_front());
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 4; c++) begin
        if (!rst_n) outst[d][c] = 0;
        else begin
          if (enq_o[d][c]) outst[d][c]++;
          if (cret_i[d][c] && outst[d][c] > 0) outst[d][c]--;
          if (outst[d][c] > depth[d]) begin
            miscompares++;
            $display("FAIL underflow dut%0d ch%0d outstanding=%0d limit=%0d",
                     d, c, outst[d][c], depth[d]);
          end
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      drive(d, 1'b0, 4'd0, 3'd0, 8'd0);
      cret_i[d] = 4'd0;
    end
    tick();
    for (int d = 0; d < 3; d++) push_exp(d, 4'b0, 4'b0, 1, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // single-channel request
    drive(0, 1, 4'b0010, 3'd3, 8'hA5);
    push_exp(0, 4'b0, 4'b0, 1, 0, 0, 0);
    tick();
    drive(0, 0, 4'b0, 3'd0, 8'h0);
    push_exp(0, 4'b0010, 4'b0010, 1, 0, 3'd3, 8'hA5);
    tick();
    push_exp(0, 4'b0, 4'b0, 1, 0, 0, 0);

    // zero mask is a no-op
    drive(0, 1, 4'b0000, 3'd7, 8'hFF);
    tick();
    drive(0, 0, 4'b0, 3'd0, 8'h0);
    push_exp(0, 4'b0, 4'b0, 1, 0, 0, 0);
    tick();

    // partial and atomic: drain ch2, then multicast 0101
    for (int d = 0; d < 2; d++) begin
      drive(d, 1, 4'b0100, 3'd1, 8'h11);
      tick();
      drive(d, 1, 4'b0100, 3'd2, 8'h22);
      push_exp(d, 4'b0100, 4'b0100, 1, 0, 3'd1, 8'h11);
      tick();
      drive(d, 0, 4'b0, 3'd0, 8'h0);
      push_exp(d, 4'b0100, 4'b0100, 1, 0, 3'd2, 8'h22);
      tick();
      push_exp(d, 4'b0, 4'b0, 1, 0, 0, 0);
      drive(d, 1, 4'b0101, 3'd5, 8'h5A);
      tick();
      drive(d, 0, 4'b0, 3'd0, 8'h0);
      if (d == 0) push_exp(d, 4'b0001, 4'b0101, 0, 0, 3'd5, 8'h5A);
      else        push_exp(d, 4'b0000, 4'b0101, 0, 0, 0, 0);
      tick();
      cret_i[d] = 4'b0100;
      if (d == 0) push_exp(d, 4'b0000, 4'b0100, 0, 0, 0, 0);
      else        push_exp(d, 4'b0000, 4'b0101, 0, 0, 0, 0);
      tick();
      cret_i[d] = 4'b0000;
      if (d == 0) push_exp(d, 4'b0100, 4'b0100, 1, 0, 3'd5, 8'h5A);
      else        push_exp(d, 4'b0101, 4'b0101, 1, 0, 3'd5, 8'h5A);
      tick();
      push_exp(d, 4'b0, 4'b0, 1, 0, 0, 0);
    end

    // back-to-back 1111 with depth 4
    for (int i = 0; i < 6; i++) begin
      drive(2, 1, 4'b1111, 3'(i), 8'h10 + 8'(i));
      if (i == 0)     push_exp(2, 4'b0, 4'b0, 1, 0, 0, 0);
      else if (i < 5) push_exp(2, 4'b1111, 4'b1111, 1, 0, 3'(i - 1), 8'h10 + 8'(i - 1));
      else            push_exp(2, 4'b0, 4'b1111, 0, 0, 0, 0);
      tick();
    end
    cret_i[2] = 4'b1111;
    push_exp(2, 4'b0, 4'b1111, 0, 0, 0, 0);
    tick();
    cret_i[2] = 4'b0000;
    push_exp(2, 4'b1111, 4'b1111, 1, 0, 3'd4, 8'h14);
    tick();
    drive(2, 0, 4'b0, 3'd0, 8'h0);
    push_exp(2, 4'b0, 4'b1111, 0, 0, 0, 0);
    tick();

    // fire+return same cycle on ch3, then an extra return overflows
    drive(0, 1, 4'b1000, 3'd6, 8'h66);
    push_exp(0, 4'b0, 4'b0, 1, 0, 0, 0);
    tick();
    drive(0, 0, 4'b0, 3'd0, 8'h0);
    cret_i[0] = 4'b1000;
    push_exp(0, 4'b1000, 4'b1000, 1, 0, 3'd6, 8'h66);
    tick();
    push_exp(0, 4'b0, 4'b0, 1, 0, 0, 0);
    tick();
    cret_i[0] = 4'b0000;
    push_exp(0, 4'b0, 4'b0, 1, 1, 0, 0);
    tick();
    push_exp(0, 4'b0, 4'b0, 1, 1, 0, 0);

    // reset while atomic request waits on ch2
    drive(1, 1, 4'b0100, 3'd7, 8'h77);
    tick();
    drive(1, 0, 4'b0, 3'd0, 8'h0);
    push_exp(1, 4'b0, 4'b0100, 0, 0, 0, 0);
    tick();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) push_exp(d, 4'b0, 4'b0, 1, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // credits restored to full depth
    drive(1, 1, 4'b0101, 3'd1, 8'h3C);
    tick();
    drive(1, 0, 4'b0, 3'd0, 8'h0);
    push_exp(1, 4'b0101, 4'b0101, 1, 0, 3'd1, 8'h3C);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(2, 1, 4'b1111, 3'(i), 8'h40 + 8'(i));
      else       drive(2, 0, 4'b0, 3'd0, 8'h0);
      if (i == 0) push_exp(2, 4'b0, 4'b0, 1, 0, 0, 0);
      else        push_exp(2, 4'b1111, 4'b1111, 1, 0, 3'(i - 1), 8'h40 + 8'(i - 1));
      tick();
    end
    push_exp(2, 4'b0, 4'b0, 1, 0, 0, 0);
    push_exp(1, 4'b0, 4'b0, 1, 0, 0, 0);
    tick();
    tick();

    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
